alu_cmd_scheduler: RTL and testbench

Queuing command scheduler between the UART receiver/transmitter and the ALU. It assembles 3-byte commands (A, B, OP) from received bytes into a small command FIFO. It issues them to the ALU one at a time, waits a fixed ALU latency, and hands each result to the UART transmitter with a start/done handshake. This lets the host stream commands back-to-back while earlier results are still being transmitted.

---
 rtl/alu_cmd_scheduler_if.sv | 32 +++
 rtl/alu_cmd_scheduler.sv | 164 ++++++++++++++++
 tb/tb_alu_cmd_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_scheduler_if.sv
// Bus bundle between the UART receiver/transmitter, the ALU and alu_cmd_scheduler.
// master = surrounding system (UART + ALU), slave = the scheduler.
interface alu_cmd_scheduler_if #(
  parameter int NB_DATA    = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               rx_done;
  logic [NB_DATA-1:0] d_in;
  logic [NB_DATA-1:0] alu_res;
  logic               tx_done;
  logic               tx_start;
  logic [NB_DATA-1:0] d_out;
  logic [NB_DATA-1:0] a;
  logic [NB_DATA-1:0] b;
  logic [NB_DATA-1:0] op;
  logic               busy;
  logic [LVL_W-1:0]   cmd_level;
  logic               drop_err;
  logic               frame_err;

  modport master (
    output rx_done, d_in, alu_res, tx_done,
    input  tx_start, d_out, a, b, op, busy, cmd_level, drop_err, frame_err
  );

  modport slave (
    input  rx_done, d_in, alu_res, tx_done,
    output tx_start, d_out, a, b, op, busy, cmd_level, drop_err, frame_err
  );
endinterface

// File: rtl/alu_cmd_scheduler.sv
// Collects 3-byte (A, B, OP) frames into a command FIFO and runs them through the ALU one at a time.
// Optional partial-frame timeout is enabled by defining RX_TIMEOUT_EN.
module alu_cmd_scheduler #(
  parameter int NB_DATA    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 1
`ifdef RX_TIMEOUT_EN
  , parameter int RX_TIMEOUT = 1000
`endif
) (
  input logic                clk,
  input logic                reset,
  alu_cmd_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = 4;

  typedef struct packed {
    logic [NB_DATA-1:0] a;
    logic [NB_DATA-1:0] b;
    logic [NB_DATA-1:0] op;
  } cmd_t;

  typedef enum logic [1:0] {GET_A, GET_B, GET_OP} col_state_t;
  typedef enum logic [1:0] {EX_IDLE, EX_WAIT, EX_START, EX_WAIT_TX} ex_state_t;

  col_state_t         col_state;
  ex_state_t          ex_state;
  logic [NB_DATA-1:0] a_lat, b_lat;
  logic               drop_err_q;

  cmd_t               mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   level;
  cmd_t               head;
  logic               fifo_full, frame_done, push, pop, timeout;

  logic [LAT_W-1:0]   lat_cnt;
  logic [NB_DATA-1:0] a_q, b_q, op_q, d_out_q;
  logic               tx_start_q, busy_q;

  // A full FIFO still accepts the frame when the executor pops in the same cycle.
  assign fifo_full  = (level == CNT_W'(FIFO_DEPTH));
  assign frame_done = bus.rx_done && (col_state == GET_OP);
  assign pop        = (ex_state == EX_IDLE) && (level != '0);
  assign push       = frame_done && (!fifo_full || pop);
  assign head       = mem[rd_ptr];

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(RX_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
  logic            frame_err_q;

  assign timeout = (col_state != GET_A) && !bus.rx_done && (to_cnt == TO_W'(RX_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      frame_err_q <= 1'b0;
    end else if (bus.rx_done || col_state == GET_A) begin
      to_cnt <= '0;
    end else if (timeout) begin
      to_cnt      <= '0;
      frame_err_q <= 1'b1;
    end else begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  assign timeout       = 1'b0;
  assign bus.frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      col_state  <= GET_A;
      a_lat      <= '0;
      b_lat      <= '0;
      drop_err_q <= 1'b0;
    end else if (timeout) begin
      col_state <= GET_A;
    end else if (bus.rx_done) begin
      unique case (col_state)
        GET_A:  begin a_lat <= bus.d_in; col_state <= GET_B;  end
        GET_B:  begin b_lat <= bus.d_in; col_state <= GET_OP; end
        GET_OP: begin
          if (!push) drop_err_q <= 1'b1;
          col_state <= GET_A;
        end
        default: col_state <= GET_A;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {a_lat, b_lat, bus.d_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + CNT_W'(1);
      else if (pop && !push) level <= level - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_state   <= EX_IDLE;
      lat_cnt    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      d_out_q    <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: default-then-override with non-blocking assignments keeps tx_start a one-cycle registered pulse.
      tx_start_q <= 1'b0;
      unique case (ex_state)
        EX_IDLE: if (pop) begin
          a_q      <= head.a;
          b_q      <= head.b;
          op_q     <= head.op;
          lat_cnt  <= LAT_W'(ALU_LAT);
          busy_q   <= 1'b1;
          ex_state <= EX_WAIT;
        end
        EX_WAIT: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (lat_cnt == LAT_W'(1)) begin
            d_out_q    <= bus.alu_res;
            tx_start_q <= 1'b1;
            ex_state   <= EX_START;
          end
        end
        EX_START: ex_state <= EX_WAIT_TX;
        EX_WAIT_TX: if (bus.tx_done) begin
          busy_q   <= 1'b0;
          ex_state <= EX_IDLE;
        end
        default: ex_state <= EX_IDLE;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.op        = op_q;
  assign bus.d_out     = d_out_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_level = level;
  assign bus.drop_err  = drop_err_q;
endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// Scoreboard bench for alu_cmd_scheduler: directed corner cases plus randomized command streams.
// Define RX_TIMEOUT_EN to also exercise the partial-frame timeout (RX_TIMEOUT=8).
module tb_alu_cmd_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_cmd_scheduler_if #(.NB_DATA(8), .FIFO_DEPTH(4)) bus ();

`ifdef RX_TIMEOUT_EN
  alu_cmd_scheduler #(.NB_DATA(8), .FIFO_DEPTH(4), .ALU_LAT(1), .RX_TIMEOUT(8)) dut (
`else
  alu_cmd_scheduler #(.NB_DATA(8), .FIFO_DEPTH(4), .ALU_LAT(1)) dut (
`endif
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [7:0] a, b, op, res;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tx_seen = 0;
  bit   tx_auto = 1'b0;
  logic tx_done_auto = 1'b0;
  logic tx_done_man  = 1'b0;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  always_comb bus.alu_res = alu_f(bus.a, bus.b, bus.op);
  assign bus.tx_done = tx_done_auto | tx_done_man;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every tx_start must match the oldest accepted command.
  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      tx_seen++;
      if (sb.size() == 0) begin
        check("spurious_tx_start_queue", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_d_out", bus.d_out, e.res);
        check("result_a", bus.a, e.a);
        check("result_b", bus.b, e.b);
        check("result_op", bus.op, e.op);
      end
    end
  end

  // Transmitter model: answers each tx_start with tx_done after 1..4 cycles when enabled.
  int cd = -1;
  always @(negedge clk) begin
    tx_done_auto = 1'b0;
    if (cd == 0) begin
      tx_done_auto = 1'b1;
      cd = -1;
    end else if (cd > 0) begin
      cd--;
    end
    if (bus.tx_start === 1'b1 && tx_auto) cd = int'($urandom_range(0, 3));
  end

  task automatic send_byte(input logic [7:0] v, input int gap);
    bus.rx_done = 1'b1;
    bus.d_in    = v;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.d_in    = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit accept);
    send_byte(a, 1);
    send_byte(b, 1);
    send_byte(op, 1);
    if (accept) sb.push_back('{a: a, b: b, op: op, res: alu_f(a, b, op)});
  endtask

  task automatic pulse_tx_done();
    tx_done_man = 1'b1;
    @(negedge clk);
    tx_done_man = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    for (int i = 0; i < 200 && tx_seen < target; i++) @(negedge clk);
    check("tx_start_seen", tx_seen >= target, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && (sb.size() != 0 || bus.busy !== 1'b0); i++) @(negedge clk);
    check("drain_queue_empty", sb.size(), 0);
    check("drain_level_zero", bus.cmd_level, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, bus.a, 0);
    check({tag, "_b"}, bus.b, 0);
    check({tag, "_op"}, bus.op, 0);
    check({tag, "_d_out"}, bus.d_out, 0);
    check({tag, "_tx_start"}, bus.tx_start, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_cmd_level"}, bus.cmd_level, 0);
    check({tag, "_drop_err"}, bus.drop_err, 0);
    check({tag, "_frame_err"}, bus.frame_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    logic [7:0] ra, rb, rop;
    reset       = 1'b1;
    bus.rx_done = 1'b0;
    bus.d_in    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // Basic command 10, 9, 2 with cycle-exact timing.
    send_byte(8'd10, 1);
    send_byte(8'd9, 1);
    send_byte(8'd2, 0);
    sb.push_back('{a: 8'd10, b: 8'd9, op: 8'd2, res: alu_f(8'd10, 8'd9, 8'd2)});
    check("t1_level_after_push", bus.cmd_level, 1);
    @(negedge clk);
    check("t1_a", bus.a, 10);
    check("t1_b", bus.b, 9);
    check("t1_op", bus.op, 2);
    check("t1_busy", bus.busy, 1);
    check("t1_tx_start_early", bus.tx_start, 0);
    check("t1_level_after_pop", bus.cmd_level, 0);
    @(negedge clk);
    check("t1_tx_start", bus.tx_start, 1);
    check("t1_d_out", bus.d_out, 3);
    @(negedge clk);
    check("t1_tx_start_one_cycle", bus.tx_start, 0);
    check("t1_busy_wait_tx", bus.busy, 1);
    pulse_tx_done();
    check("t1_idle_after_tx_done", bus.busy, 0);

    // tx_done during WAIT must be ignored.
    send_byte(8'd7, 1);
    send_byte(8'd5, 1);
    send_byte(8'd0, 0);
    sb.push_back('{a: 8'd7, b: 8'd5, op: 8'd0, res: alu_f(8'd7, 8'd5, 8'd0)});
    @(negedge clk);
    tx_done_man = 1'b1;
    @(negedge clk);
    tx_done_man = 1'b0;
    check("t2_tx_start_after_early_done", bus.tx_start, 1);
    repeat (4) @(negedge clk);
    check("t2_still_waiting_tx", bus.busy, 1);
    pulse_tx_done();
    check("t2_idle", bus.busy, 0);

    // Push and pop in the same cycle while full.
    base = tx_seen;
    for (int i = 0; i < 5; i++) send_cmd(8'(20 + i), 8'(3 * i), 8'(i), 1'b1);
    wait_tx(base + 1);
    check("t3_level_full", bus.cmd_level, 4);
    send_byte(8'd100, 1);
    send_byte(8'd50, 1);
    tx_done_man = 1'b1;
    @(negedge clk);
    tx_done_man = 1'b0;
    bus.rx_done = 1'b1;
    bus.d_in    = 8'd1;
    sb.push_back('{a: 8'd100, b: 8'd50, op: 8'd1, res: alu_f(8'd100, 8'd50, 8'd1)});
    @(negedge clk);
    bus.rx_done = 1'b0;
    check("t3_level_unchanged", bus.cmd_level, 4);
    check("t3_no_drop", bus.drop_err, 0);
    check("t3_busy_after_pop", bus.busy, 1);
    tx_auto = 1'b1;
    wait_drain();

    // Randomized stream with a live transmitter.
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 500 && sb.size() >= 4; i++) @(negedge clk);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 8'($urandom);
      send_byte(ra, int'($urandom_range(0, 2)));
      send_byte(rb, int'($urandom_range(0, 2)));
      send_byte(rop, int'($urandom_range(0, 2)));
      sb.push_back('{a: ra, b: rb, op: rop, res: alu_f(ra, rb, rop)});
    end
    wait_drain();
    check("rand_no_drop", bus.drop_err, 0);

    // Overflow: one executing, four queued, sixth dropped.
    tx_auto = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(8'(40 + i), 8'(i + 1), 8'(i), 1'b1);
    check("t4_level_max", bus.cmd_level, 4);
    check("t4_drop_clear", bus.drop_err, 0);
    send_cmd(8'd99, 8'd98, 8'd97, 1'b0);
    check("t4_level_after_drop", bus.cmd_level, 4);
    check("t4_drop_err", bus.drop_err, 1);
    pulse_tx_done();
    tx_auto = 1'b1;
    wait_drain();
    check("t4_drop_sticky", bus.drop_err, 1);

    // Reset during WAIT_TX with two commands queued and a partial frame.
    tx_auto = 1'b0;
    base = tx_seen;
    for (int i = 0; i < 3; i++) send_cmd(8'(60 + i), 8'(7 + i), 8'(i), 1'b1);
    wait_tx(base + 1);
    check("t5_level_before_reset", bus.cmd_level, 2);
    send_byte(8'h77, 1);
    do_reset();
    sb.delete();
    check_all_zero("t5_after_reset");
    repeat (10) @(negedge clk);
    check("t5_still_idle", bus.busy, 0);
    tx_auto = 1'b1;
    send_cmd(8'd4, 8'd5, 8'd6, 1'b1);
    wait_drain();
    check("t5_new_frame_a", bus.a, 4);

`ifdef RX_TIMEOUT_EN
    // Partial frame timeout.
    send_byte(8'd5, 0);
    send_byte(8'd6, 0);
    repeat (6) @(negedge clk);
    check("t6_no_timeout_yet", bus.frame_err, 0);
    repeat (2) @(negedge clk);
    check("t6_frame_err", bus.frame_err, 1);
    send_cmd(8'd1, 8'd2, 8'd3, 1'b1);
    wait_drain();
    check("t6_frame_err_sticky", bus.frame_err, 1);
`else
    check("no_frame_err", bus.frame_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
